instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch and program-counter unit for the PIC16F-compatible core; the producer side of the decoder's fetch-control interface. Owns the 13-bit program counter, the 8-level circular hardware return stack, a one-word prefetch buffer fed by synchronous program memory, and the `instr_current` register. Acts on the decoder's `instr_rd_en`, `instr_flush`, `pc_incr_en` and `pc_j_en` strobes, and returns the instruction word the decoder consumes.

## Interface
- `PC_WIDTH`, 13, program counter and program memory address width
- `STACK_DEPTH`, 8, return stack entries (power of two)
- `RESET_VECTOR`, 13'h0000, PC value after reset
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_rd_en`  in  1  load `instr_current` from the prefetch buffer
- `instr_flush`  in  1  load `instr_current` with NOP (14'h0000)
- `pc_incr_en`  in  1  PC <= PC+1
- `pc_j_en`  in  1  PC <= {pclath[4:3], instr_current[10:0]}
- `stack_push`  in  1  push current PC (qualifies `pc_j_en` for CALL)
- `stack_pop`  in  1  PC <= top of stack (RETURN/RETLW/RETFIE)
- `pclath`  in  5  PCLATH register contents
- `prog_addr`  out  PC_WIDTH  program memory address, equals PC
- `prog_rd_en`  out  1  program memory read strobe
- `prog_data`  in  14  word for the address read on the previous cycle
- `instr_current`  out  14  instruction being executed
- `pc`  out  PC_WIDTH  program counter (address of the prefetched word)
- `fetch_underrun`  out  1  sticky: `instr_rd_en` arrived with prefetch invalid

## Operation
- PC always addresses the next instruction; the prefetch buffer holds the word at PC plus a valid bit.
- PC update priority per cycle: `stack_pop` > `pc_j_en` > `pc_incr_en`. `pc_incr_en` wraps 13'h1FFF -> 13'h0000.
- Jump target uses only `pclath[4:3]` and `instr_current[10:0]`; bits above are zero.
- `stack_push` with `pc_j_en`: stack[ptr] <= PC (pre-jump), ptr <= ptr+1, PC <= target. `stack_push` without `pc_j_en` is ignored.
- `stack_pop`: ptr <= ptr-1, PC <= stack[ptr-1]. If push and pop coincide, pop wins and push is ignored.
- Stack is circular with no error flags: the 9th push overwrites the oldest entry; a pop on an empty stack wraps the pointer and returns that slot.
- Any PC update clears prefetch valid and schedules a read of the new PC.
- `instr_current` update: `instr_flush` -> 14'h0000 (wins over `instr_rd_en`); else `instr_rd_en` -> prefetch word if valid, else 14'h0000 with `fetch_underrun` set.
- `fetch_underrun` clears only on reset.

## Timing
- Reset values (asynchronous): PC = RESET_VECTOR; `instr_current` = 14'h0000; prefetch invalid; stack pointer 0; all stack entries 0; `fetch_underrun` 0; `prog_rd_en` 0.
- `prog_addr` is combinational from PC.
- `prog_rd_en` is 1 in the first cycle after reset release and in the cycle after every PC update. `prog_data` is captured on the next edge, setting prefetch valid.
- If PC changes on the edge that ends a read cycle, that read's data is discarded and the read is reissued.
- Fetch latency is 2 cycles from a PC update to valid prefetch, which is hidden inside the decoder's 4-cycle instruction.
- Reset asserted mid-operation aborts any in-flight read. No capture occurs on the cycle after release.
- Sequencing:
  - After reset, the first executed instruction is a forced NOP. Its Q3 `instr_rd_en`+`pc_incr_en` loads word[RESET_VECTOR] and sets PC to RESET_VECTOR+1.
  - GOTO/CALL: `instr_flush`+`pc_j_en` -> NOP, then word[target], then PC = target+1.
  - Skip: `instr_flush`+`pc_incr_en` discards the prefetched word.

## Test plan
- Reset release with memory word[n] = 14'h3000+n, NOP strobes every 4 cycles:
  - `prog_rd_en` is high in cycle 1 with `prog_addr` 0.
  - First `instr_rd_en`+`pc_incr_en` loads 14'h3000 and sets PC to 1.
  - Next strobe loads 14'h3001.
- GOTO: `instr_current` = 14'h2855 with `pclath` = 5'b11000 and `instr_flush`+`pc_j_en`:
  - PC becomes 13'h1855 and `instr_current` becomes 0.
  - Next `instr_rd_en`+`pc_incr_en` loads word[13'h1855] and sets PC to 13'h1856.
- Skip: at PC = 13'h0010, `instr_flush`+`pc_incr_en` -> PC 13'h0011, `instr_current` 0. Word[13'h0010] is never loaded.
- Stack:
  - 9 CALLs from PCs 1..9, then 9 pops, give PC sequence 9,8,7,6,5,4,3,2,9 (circular overwrite of the oldest entry).
  - Simultaneous push+pop performs only the pop.
- Hazards:
  - `instr_rd_en` 1 cycle after `pc_j_en` loads 0 and sets `fetch_underrun` = 1.
  - `instr_flush`+`instr_rd_en` together load 0.
  - `pc_incr_en` at 13'h1FFF gives PC 13'h0000.
- `rst_n` low while `prog_rd_en` is high: all outputs return to reset values immediately. The stale `prog_data` on the following cycle is not captured.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Program counter, 8-level circular return stack, one-word prefetch buffer
// and the instruction register for the PIC16F-compatible core.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   instr_rd_en       load instr_current from the prefetch buffer
//   instr_flush       load instr_current with NOP (wins over instr_rd_en)
//   pc_incr_en        PC <= PC + 1 (wraps)
//   pc_j_en           PC <= {pclath[4:3], instr_current[10:0]}
//   stack_push        with pc_j_en: push pre-jump PC (CALL)
//   stack_pop         PC <= top of stack (highest PC-update priority)
//   pclath            PCLATH register contents
//   prog_addr         program memory address (= PC)
//   prog_rd_en        program memory read strobe
//   prog_data         word for the address read on the previous cycle
//   instr_current     instruction being executed
//   pc                program counter (address of the prefetched word)
//   fetch_underrun    sticky: instr_rd_en seen while prefetch invalid
module instr_fetch_unit #(
    parameter int                   PC_WIDTH     = 13,
    parameter int                   STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_rd_en,
    input  logic                instr_flush,
    input  logic                pc_incr_en,
    input  logic                pc_j_en,
    input  logic                stack_push,
    input  logic                stack_pop,
    input  logic [4:0]          pclath,
    output logic [PC_WIDTH-1:0] prog_addr,
    output logic                prog_rd_en,
    input  logic [13:0]         prog_data,
    output logic [13:0]         instr_current,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_underrun
);

    localparam int                  SP_W   = $clog2(STACK_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
    localparam logic [SP_W-1:0]     SP_ONE = 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [13:0]         instr_q, instr_d;
    logic [13:0]         pf_word_q, pf_word_d;
    logic                pf_valid_q, pf_valid_d;
    logic                rd_q, rd_d;          // read cycle: address on the bus
    logic                pend_q, pend_d;      // data cycle: word arrives on prog_data
    logic                started_q, started_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
    logic                underrun_q, underrun_d;

    logic [PC_WIDTH-1:0] jump_target;
    logic [SP_W-1:0]     sp_dec;
    logic                pc_upd;
    logic                pclath_unused;

    // Only the page-select bits of PCLATH reach the PC on a jump.
    assign pclath_unused = ^pclath[2:0];

    assign jump_target = PC_WIDTH'({pclath[4:3], instr_q[10:0]});
    assign sp_dec      = sp_q - SP_ONE;

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pf_word_d  = pf_word_q;
        pf_valid_d = pf_valid_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        underrun_d = underrun_q;
        started_d  = 1'b1;
        pc_upd     = 1'b0;

        if (stack_pop) begin
            // Pop wins over a coincident push; the push is dropped.
            sp_d   = sp_dec;
            pc_d   = stack_q[sp_dec];
            pc_upd = 1'b1;
        end else if (pc_j_en) begin
            if (stack_push) begin
                stack_d[sp_q] = pc_q;
                sp_d          = sp_q + SP_ONE;
            end
            pc_d   = jump_target;
            pc_upd = 1'b1;
        end else if (pc_incr_en) begin
            pc_d   = pc_q + PC_ONE;
            pc_upd = 1'b1;
        end

        // Reads run as a two-cycle pipeline (address, then data). A PC change
        // anywhere in it discards the word and restarts at the new PC.
        rd_d   = pc_upd | ~started_q;
        pend_d = rd_q & ~pc_upd;

        if (pc_upd) begin
            pf_valid_d = 1'b0;
        end else if (pend_q) begin
            pf_valid_d = 1'b1;
            pf_word_d  = prog_data;
        end

        if (instr_flush) begin
            instr_d = 14'h0000;
        end else if (instr_rd_en) begin
            if (pf_valid_q) begin
                instr_d = pf_word_q;
            end else begin
                instr_d    = 14'h0000;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            instr_q    <= 14'h0000;
            pf_word_q  <= 14'h0000;
            pf_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            pend_q     <= 1'b0;
            started_q  <= 1'b0;
            sp_q       <= '0;
            underrun_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pf_word_q  <= pf_word_d;
            pf_valid_q <= pf_valid_d;
            rd_q       <= rd_d;
            pend_q     <= pend_d;
            started_q  <= started_d;
            sp_q       <= sp_d;
            underrun_q <= underrun_d;
            stack_q    <= stack_d;
        end
    end

    assign prog_addr      = pc_q;
    assign prog_rd_en     = rd_q;
    assign instr_current  = instr_q;
    assign pc             = pc_q;
    assign fetch_underrun = underrun_q;

endmodule
